ks_pipe_adder: RTL

Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready flow control. It generalises the fixed 28-bit combinational prefix tree to any `WIDTH`, with a configurable register rank every `REG_EVERY` prefix levels, an add/subtract mode, and a passthrough tag. It sits in the floating-point datapath wherever mantissa add/subtract must run at full clock rate and tolerate downstream stalls.

---
 rtl/ks_pipe_adder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ks_pipe_adder.sv
// ks_pipe_adder: pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
//
// The operands are first turned into propagate/generate vectors (rank 0). Then
// clog2(WIDTH) prefix levels follow, with a register rank after every REG_EVERY
// levels (ranks 1..R). A final output rank (rank R+1) forms sum, cout and ovf.
// Each rank loads only when it is empty or the rank below it is moving, so a
// bubble anywhere in the pipe is squeezed out even while the output is stalled.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready is combinational from out_ready)
//   a, b, cin, op_sub   operands, carry-in (add only), subtract select
//   tag_in              sideband that travels with the beat
//   out_valid/out_ready result handshake
//   sum, cout, ovf      result, carry out of MSB (1 = no borrow on subtract),
//                       two's-complement overflow
//   tag_out             sideband of the current result

module ks_pipe_adder #(
  parameter int unsigned WIDTH     = 28,
  parameter int unsigned REG_EVERY = 1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int Levels = $clog2(WIDTH);
  localparam int RegEv  = int'(REG_EVERY);
  localparam int Ranks  = (Levels + RegEv - 1) / RegEv;
  localparam int Msb    = int'(WIDTH) - 1;

  // Ranks 0..Ranks carry the prefix state; rank Ranks+1 is the output register.
  logic [Ranks:0]                 vld_q;
  logic [Ranks:0][WIDTH-1:0]      porig_q;
  logic [Ranks:0][WIDTH-1:0]      gg_q;
  logic [Ranks-1:0][WIDTH-1:0]    pp_q;
  logic [Ranks:0]                 c0_q;
  logic [Ranks:0]                 amsb_q;
  logic [Ranks:0]                 bmsb_q;
  logic [Ranks:0][TAG_W-1:0]      tag_q;

  logic                           out_valid_q;
  logic [WIDTH-1:0]               sum_q;
  logic                           cout_q;
  logic                           ovf_q;
  logic [TAG_W-1:0]               tag_out_q;

  logic [WIDTH-1:0]               b_eff;
  logic                           c0_eff;
  logic [Ranks:0][WIDTH-1:0]      gg_d;
  logic [Ranks-1:0][WIDTH-1:0]    pp_d;
  logic [WIDTH-1:0]               g_t;
  logic [WIDTH-1:0]               p_t;

  logic [Ranks+1:0]               adv;
  logic                           adv_t;

  logic [WIDTH-1:0]               carry;
  logic [WIDTH-1:0]               sum_d;
  logic                           cout_d;
  logic                           ovf_d;

  // Operand conditioning and the prefix levels that sit in front of each rank.
  always_comb begin
    gg_d   = '0;
    pp_d   = '0;
    g_t    = '0;
    p_t    = '0;
    b_eff  = op_sub ? ~b : b;
    c0_eff = op_sub | cin;

    gg_d[0] = a & b_eff;
    pp_d[0] = a ^ b_eff;

    for (int r = 1; r <= Ranks; r++) begin
      g_t = gg_q[r-1];
      p_t = pp_q[r-1];
      // Fold the carry-in into bit 0 so the tree output is the true carry vector.
      if (r == 1) begin
        g_t[0] = g_t[0] | (p_t[0] & c0_q[0]);
      end
      for (int k = 0; k < Levels; k++) begin
        if (k / RegEv == r - 1) begin
          // Walk downwards so each cell still sees the previous level's lower bit.
          for (int i = Msb; i >= (1 << k); i--) begin
            g_t[i] = g_t[i] | (p_t[i] & g_t[i - (1 << k)]);
            p_t[i] = p_t[i] & p_t[i - (1 << k)];
          end
        end
      end
      gg_d[r] = g_t;
      if (r < Ranks) begin
        pp_d[r] = p_t;
      end
    end
  end

  // Output rank: carries are the group generates shifted up one, c0 at bit 0.
  always_comb begin
    carry  = {gg_q[Ranks][WIDTH-2:0], c0_q[Ranks]};
    sum_d  = porig_q[Ranks] ^ carry;
    cout_d = gg_q[Ranks][WIDTH-1];
    ovf_d  = (amsb_q[Ranks] == bmsb_q[Ranks]) && (sum_d[WIDTH-1] != amsb_q[Ranks]);
  end

  // A rank may move when it is empty or everything downstream of it moves.
  always_comb begin
    adv          = '0;
    adv_t        = ~out_valid_q | out_ready;
    adv[Ranks+1] = adv_t;
    for (int k = Ranks; k >= 0; k--) begin
      adv_t  = ~vld_q[k] | adv_t;
      adv[k] = adv_t;
    end
  end

  assign in_ready = adv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      porig_q     <= '0;
      gg_q        <= '0;
      pp_q        <= '0;
      c0_q        <= '0;
      amsb_q      <= '0;
      bmsb_q      <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tag_out_q   <= '0;
    end else begin
      if (adv[0]) begin
        vld_q[0]   <= in_valid;
        porig_q[0] <= pp_d[0];
        gg_q[0]    <= gg_d[0];
        pp_q[0]    <= pp_d[0];
        c0_q[0]    <= c0_eff;
        amsb_q[0]  <= a[WIDTH-1];
        bmsb_q[0]  <= b_eff[WIDTH-1];
        tag_q[0]   <= tag_in;
      end
      for (int k = 1; k <= Ranks; k++) begin
        if (adv[k]) begin
          vld_q[k]   <= vld_q[k-1];
          porig_q[k] <= porig_q[k-1];
          gg_q[k]    <= gg_d[k];
          c0_q[k]    <= c0_q[k-1];
          amsb_q[k]  <= amsb_q[k-1];
          bmsb_q[k]  <= bmsb_q[k-1];
          tag_q[k]   <= tag_q[k-1];
          if (k < Ranks) begin
            pp_q[k] <= pp_d[k];
          end
        end
      end
      if (adv[Ranks+1]) begin
        out_valid_q <= vld_q[Ranks];
        sum_q       <= sum_d;
        cout_q      <= cout_d;
        ovf_q       <= ovf_d;
        tag_out_q   <= tag_q[Ranks];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign tag_out   = tag_out_q;

endmodule
